// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a 2-flop input synchroniser,
// false-start rejection, per-word parity/framing status and a first-word-fall-through
// receive FIFO with a sticky overrun flag.
module uart_rx_fifo #(
  parameter int NBIT       = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [NBIT-1:0]               data_out,
  output logic                          data_valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_TIME = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam int CNT_W    = $clog2(BIT_TIME);
  localparam int BCNT_W   = $clog2(NBIT + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W  = NBIT + 2;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(NBIT - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);
  localparam logic [AW:0]       DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic              ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic rx_fall;

  // Two-flop synchroniser plus one history flop; preset high to match an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop capture the pre-edge value,
      // so the three stages really form a shift chain.
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NBIT-1:0]     shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                push;

  // Receiver state, baud counter, bit counter, shift register and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by the baud counter.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[NBIT-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s_q) != ODD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = S_PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FWFT receive FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count;
  logic [ENTRY_W-1:0] entry_w, head_q, head_d;
  logic               empty, full, pop, wr_en, ovf;
  logic               overrun_q, overrun_d;

  assign entry_w  = {ferr_q, perr_q, shift_q};
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_L);
  assign pop      = rd_en & ~empty;
  assign wr_en    = push & (~full | pop);
  assign ovf      = push & full & ~pop;
  assign wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
  assign rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
  assign overrun_d = (overrun_q & ~clr_err) | ovf;

  // Head register: next head is the word being written when it lands at the read
  // pointer, otherwise the stored entry; holds its value when the FIFO drains.
  always_comb begin
    head_d = head_q;
    if (rd_ptr_d != wr_ptr_d) begin
      if (rd_ptr_d == wr_ptr_q) head_d = entry_w;
      else                      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // Pointers, head register and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; pointers alone define which entries are valid.
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_w;
  end

  assign data_out   = head_q[NBIT-1:0];
  assign parity_err = head_q[NBIT];
  assign frame_err  = head_q[NBIT+1];
  assign data_valid = ~empty;
  assign overrun    = overrun_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: two instances (8N1 and 8E2) at 16 clks/bit.
// Expected entries are queued when a frame is sent; per-instance monitors pop
// and compare whenever a read handshake (rd_en with data_valid) occurs.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BT       = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, rx_a, rd_a, clr_a;
  logic [7:0] dout_a;
  logic       dv_a, pe_a, fe_a, ov_a;
  logic [2:0] cnt_a;

  logic       reset_b, rx_b, rd_b, clr_b;
  logic [7:0] dout_b;
  logic       dv_b, pe_b, fe_b, ov_b;
  logic [2:0] cnt_b;

  uart_rx_fifo #(.NBIT(8), .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset_a), .serial_in(rx_a), .rd_en(rd_a), .clr_err(clr_a),
    .data_out(dout_a), .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a),
    .overrun(ov_a), .fifo_count(cnt_a)
  );

  uart_rx_fifo #(.NBIT(8), .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset_b), .serial_in(rx_b), .rd_en(rd_b), .clr_err(clr_b),
    .data_out(dout_b), .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b),
    .overrun(ov_b), .fifo_count(cnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected entries {ferr, perr, data}
  logic [9:0] exp_a [$];
  logic [9:0] exp_b [$];
  logic [9:0] mon_a_e, mon_b_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for instance A: compare the head on every accepted read.
  always @(negedge clk) begin
    if (!reset_a && rd_a && dv_a) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_pop: got 0x%0h expected no entry", dout_a);
      end else begin
        mon_a_e = exp_a.pop_front();
        check("a_pop_data", 32'(dout_a), 32'(mon_a_e[7:0]));
        check("a_pop_perr", 32'(pe_a), 32'(mon_a_e[8]));
        check("a_pop_ferr", 32'(fe_a), 32'(mon_a_e[9]));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!reset_b && rd_b && dv_b) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_pop: got 0x%0h expected no entry", dout_b);
      end else begin
        mon_b_e = exp_b.pop_front();
        check("b_pop_data", 32'(dout_b), 32'(mon_b_e[7:0]));
        check("b_pop_perr", 32'(pe_b), 32'(mon_b_e[8]));
        check("b_pop_ferr", 32'(fe_b), 32'(mon_b_e[9]));
      end
    end
  end

  task automatic set_line(input bit sel_b, input logic v);
    if (sel_b) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic set_reset(input bit sel_b, input logic v);
    if (sel_b) reset_b = v;
    else       reset_a = v;
  endtask

  // Drives one frame, bit k starting 1 time unit after posedge P0+BT*k.
  // rst_bit >= 0 asserts reset 4 clks into that bit and releases it after the frame.
  task automatic drive_frame(input bit sel_b, input logic [8:0] data, input int nbit,
                             input bit has_par, input logic par, input int nstop,
                             input logic [1:0] stops, input int rst_bit);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbit; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(par);
    for (int s = 0; s < nstop; s++) bits.push_back(stops[s]);
    @(posedge clk);
    for (int k = 0; k < bits.size(); k++) begin
      #1 set_line(sel_b, bits[k]);
      if (k == rst_bit) begin
        repeat (4) @(posedge clk);
        #1 set_reset(sel_b, 1'b1);
        repeat (BT - 4) @(posedge clk);
      end else begin
        repeat (BT) @(posedge clk);
      end
    end
    if (rst_bit >= 0) #1 set_reset(sel_b, 1'b0);
  endtask

  task automatic pop(input bit sel_b);
    @(posedge clk);
    #1;
    if (sel_b) rd_b = 1'b1; else rd_a = 1'b1;
    @(posedge clk);
    #1;
    if (sel_b) rd_b = 1'b0; else rd_a = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    reset_a = 1'b1; rx_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
    reset_b = 1'b1; rx_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_a_data", 32'(dout_a), 0);
    check("rst_a_valid", 32'(dv_a), 0);
    check("rst_a_errs", 32'({pe_a, fe_a, ov_a}), 0);
    check("rst_a_count", 32'(cnt_a), 0);
    check("rst_b_count", 32'(cnt_b), 0);

    // 1: 8N1 0xA5
    exp_a.push_back({2'b00, 8'hA5});
    drive_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    settle(8);
    check("t1_valid", 32'(dv_a), 1);
    check("t1_data", 32'(dout_a), 'hA5);
    check("t1_errs", 32'({pe_a, fe_a}), 0);
    check("t1_count", 32'(cnt_a), 1);
    pop(1'b0);
    @(negedge clk);
    check("t1_count_after_pop", 32'(cnt_a), 0);
    check("t1_valid_after_pop", 32'(dv_a), 0);
    check("t1_data_held", 32'(dout_a), 'hA5);

    // 2: 8E2, 0x07 with correct then wrong parity bit
    exp_b.push_back({2'b00, 8'h07});
    drive_frame(1'b1, 9'h007, 8, 1'b1, 1'b1, 2, 2'b11, -1);
    exp_b.push_back({2'b01, 8'h07});
    drive_frame(1'b1, 9'h007, 8, 1'b1, 1'b0, 2, 2'b11, -1);
    settle(24);
    check("t2_count", 32'(cnt_b), 2);
    check("t2_head_perr", 32'(pe_b), 0);
    pop(1'b1);
    @(negedge clk);
    check("t2_second_perr", 32'(pe_b), 1);
    pop(1'b1);

    // 3: 8E2, 0x3C with second stop bit low, line then held low
    exp_b.push_back({2'b10, 8'h3C});
    drive_frame(1'b1, 9'h03C, 8, 1'b1, 1'b0, 2, 2'b01, -1);
    settle(4 * BT);
    check("t3_count", 32'(cnt_b), 1);
    check("t3_ferr", 32'(fe_b), 1);
    check("t3_data", 32'(dout_b), 'h3C);
    rx_b = 1'b1;
    settle(3 * BT);
    check("t3_no_retrigger", 32'(cnt_b), 1);
    pop(1'b1);

    // 4: 4-clk low glitch on idle line, then a real frame
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    settle(3 * BT);
    check("t4_no_push", 32'(cnt_a), 0);
    exp_a.push_back({2'b00, 8'h3B});
    drive_frame(1'b0, 9'h03B, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    settle(8);
    check("t4_after_glitch_count", 32'(cnt_a), 1);
    pop(1'b0);

    // 5: five words without reads -> 0x05 dropped, overrun set
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_a.push_back({2'b00, 8'(i)});
      drive_frame(1'b0, 9'(i), 8, 1'b0, 1'b0, 1, 2'b11, -1);
    end
    settle(8);
    check("t5_count", 32'(cnt_a), 4);
    check("t5_overrun", 32'(ov_a), 1);
    check("t5_head", 32'(dout_a), 'h01);
    @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    @(negedge clk);
    check("t5_overrun_cleared", 32'(ov_a), 0);

    // 6b: FIFO full, push coincides with a pop (push lands on edge P0+156)
    exp_a.push_back({2'b00, 8'h06});
    fork
      drive_frame(1'b0, 9'h006, 8, 1'b0, 1'b0, 1, 2'b11, -1);
      begin
        repeat (12 + BT * 9) @(posedge clk);
        #1 rd_a = 1'b1;
        @(posedge clk);
        #1 rd_a = 1'b0;
      end
    join
    settle(8);
    check("t6_full_pushpop_count", 32'(cnt_a), 4);
    check("t6_full_pushpop_overrun", 32'(ov_a), 0);
    check("t6_full_pushpop_head", 32'(dout_a), 'h02);
    for (int i = 0; i < 4; i++) pop(1'b0);
    @(negedge clk);
    check("t6_drained", 32'(cnt_a), 0);

    // 6a: reset during data bit 3 of 0x55, then 0x66
    drive_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1, 2'b11, 4);
    settle(3 * BT);
    check("t6_rst_count", 32'(cnt_a), 0);
    check("t6_rst_valid", 32'(dv_a), 0);
    check("t6_rst_data", 32'(dout_a), 0);
    exp_a.push_back({2'b00, 8'h66});
    drive_frame(1'b0, 9'h066, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    settle(8);
    check("t6_next_frame_count", 32'(cnt_a), 1);
    pop(1'b0);

    settle(4);
    check("a_queue_empty", 32'(exp_a.size()), 0);
    check("b_queue_empty", 32'(exp_b.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
